// File: rtl/sprite_fetch_pkg.sv
// sprite_fetch_pkg: shared widths, FSM states and coordinate word indices for the sprite fetch path
package sprite_fetch_pkg;
    localparam int CORDW     = 16;
    localparam int NUM_WORDS = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        DATA   = 3'd2,
        COMMIT = 3'd3
    } state_t;

    localparam logic [2:0] IDX_MX  = 3'd0;
    localparam logic [2:0] IDX_MY  = 3'd1;
    localparam logic [2:0] IDX_P1X = 3'd2;
    localparam logic [2:0] IDX_P1Y = 3'd3;
    localparam logic [2:0] IDX_P2X = 3'd4;
    localparam logic [2:0] IDX_P2Y = 3'd5;
endpackage

// File: rtl/sprite_fetch_ctrl_edge_det.sv
// edge_det: registered rising-edge detector for frame/line strobes
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) d_q <= 1'b0;
        else     d_q <= d;

    assign rise = d & ~d_q;
endmodule

// File: rtl/sprite_fetch_ctrl.sv
// sprite_fetch_ctrl: per-frame fetch of sprite coordinate words with atomic commit to the renderers
// Optional grant timeout abort enabled by defining SPR_FETCH_TIMEOUT_EN.
module sprite_fetch_ctrl #(
    parameter int                CORDW     = sprite_fetch_pkg::CORDW,
    parameter int                NUM_WORDS = sprite_fetch_pkg::NUM_WORDS,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 255
) (
    input  logic                       clk_50m,
    input  logic                       rst,
    input  logic                       frame,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_gnt,
    input  logic [CORDW-1:0]           mem_rdata,
    output logic [2:0]                 vga_counter,
    output logic [NUM_WORDS*CORDW-1:0] coords,
    output logic                       update_done,
    output logic                       overrun,
    output logic                       fetch_err
);
    import sprite_fetch_pkg::*;

    state_t                          state, state_nx;
    logic [2:0]                      idx;
    logic                            last, frame_rise, tmo;
    logic [NUM_WORDS-1:0][CORDW-1:0] shadow;

    edge_det u_frame (.clk(clk_50m), .rst(rst), .d(frame), .rise(frame_rise));

    assign last        = idx == 3'(NUM_WORDS - 1);
    assign vga_counter = idx;
    assign mem_addr    = BASE_ADDR + ADDR_W'(idx);

`ifdef SPR_FETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk_50m or posedge rst)
        if (rst) wait_cnt <= '0;
        else     wait_cnt <= (state == REQ && !mem_gnt) ? wait_cnt + 8'd1 : 8'd0;

    assign tmo = state == REQ && wait_cnt == 8'(TIMEOUT);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_50m or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx    = state;
        mem_req     = 1'b0;
        update_done = 1'b0;
        fetch_err   = 1'b0;
        case (state)
            IDLE:    state_nx = frame_rise ? REQ : IDLE;
            REQ: begin
                mem_req   = !tmo;
                fetch_err = tmo;
                state_nx  = tmo ? IDLE : mem_gnt ? DATA : REQ;
            end
            DATA:    state_nx = last ? COMMIT : REQ;
            COMMIT: begin
                update_done = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // coords only ever load from the complete shadow set, so partial fetches stay invisible
    always_ff @(posedge clk_50m or posedge rst)
        if (rst) begin
            idx     <= '0;
            shadow  <= '0;
            coords  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= overrun | (frame_rise && state != IDLE);
            if (state == DATA) begin
                shadow[idx] <= mem_rdata;
                idx         <= last ? 3'd0 : idx + 3'd1;
            end
            if (tmo) idx <= '0;
            if (state == COMMIT) coords <= shadow;
        end
endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// tb_sprite_fetch_ctrl: directed self-checking bench for sprite_fetch_ctrl
module tb_sprite_fetch_ctrl;
    localparam int CW = 16;
    localparam int NW = 6;
    localparam int AW = 16;
    localparam logic [95:0] V1 = {16'd600, 16'd500, 16'd400, 16'd300, 16'd200, 16'd100};
    localparam logic [95:0] V2 = {16'd12, 16'd11, 16'd10, 16'd9, 16'd8, 16'd7};

    logic           clk_50m = 1'b0;
    logic           rst = 1'b1;
    logic           frame = 1'b0;
    logic           mem_gnt = 1'b0;
    logic [CW-1:0]  mem_rdata = '0;
    logic           mem_req, update_done, overrun, fetch_err;
    logic [AW-1:0]  mem_addr;
    logic [2:0]     vga_counter;
    logic [NW*CW-1:0] coords;

    logic [CW-1:0] mem_tab [8];
    int total = 0;
    int bad = 0;
    int gcnt = 0;
    int stall_left = 0;
    bit stalling = 1'b0;
    bit gnt_off = 1'b0;

    always #10 clk_50m = ~clk_50m;

    sprite_fetch_ctrl #(.TIMEOUT(20)) dut (
        .clk_50m(clk_50m), .rst(rst), .frame(frame),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .vga_counter(vga_counter), .coords(coords), .update_done(update_done),
        .overrun(overrun), .fetch_err(fetch_err)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // memory/arbiter model: data follows the address, grants are stalled on word 2 when asked
    task automatic tick();
        @(negedge clk_50m);
        mem_rdata = mem_tab[mem_addr[2:0]];
        if (stall_left > 0 && (stalling || (mem_req && mem_addr == 16'd2))) begin
            stalling = 1'b1;
            mem_gnt  = 1'b0;
            stall_left--;
            check("stall_hold", 96'({mem_req, mem_addr}), 96'({1'b1, 16'd2}));
        end else begin
            stalling = 1'b0;
            mem_gnt  = !gnt_off;
        end
        if (mem_req && mem_gnt) begin
            check("addr", 96'(mem_addr), 96'(gcnt));
            gcnt++;
        end
    endtask

    task automatic set_tab(input logic [95:0] v);
        for (int i = 0; i < 8; i++) mem_tab[i] = (i < NW) ? v[i*16 +: 16] : 16'hdead;
    endtask

    task automatic fetch(input logic [95:0] old, input bit hold, input int re_at, output int lat);
        gcnt  = 0;
        frame = 1'b1;
        lat   = 0;
        while (lat < 200) begin
            tick();
            lat++;
            check("coords_hold", coords, old);
            if (update_done) break;
            if (!hold && lat == 1) frame = 1'b0;
            if (re_at > 0 && lat == re_at) frame = 1'b1;
            if (re_at > 0 && lat == re_at + 1) frame = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int lat, n, k, e;
        set_tab(V1);
        repeat (3) tick();
        check("rst_req", 96'(mem_req), 96'(0));
        check("rst_addr", 96'(mem_addr), 96'(0));
        check("rst_cnt", 96'(vga_counter), 96'(0));
        check("rst_coords", coords, 96'(0));
        check("rst_done", 96'(update_done), 96'(0));
        check("rst_ovr", 96'(overrun), 96'(0));
        check("rst_err", 96'(fetch_err), 96'(0));
        rst = 1'b0;
        repeat (2) tick();

        // basic fetch with frame held high afterwards
        fetch(96'(0), 1'b1, 0, lat);
        check("lat_basic", 96'(lat), 96'(13));
        check("gnt_count", 96'(gcnt), 96'(6));
        tick();
        check("coords_v1", coords, V1);
        check("done_pulse", 96'(update_done), 96'(0));
        n = 0;
        repeat (5) begin tick(); n += int'(mem_req); end
        check("held_no_refetch", 96'(n), 96'(0));
        check("ovr_held", 96'(overrun), 96'(0));
        frame = 1'b0;
        tick();

        // new values stay hidden until commit
        set_tab(V2);
        fetch(V1, 1'b0, 0, lat);
        check("lat_v2", 96'(lat), 96'(13));
        tick();
        check("coords_v2", coords, V2);

        // grant stall on word 2
        set_tab(V1);
        stall_left = 10;
        fetch(V2, 1'b0, 0, lat);
        check("lat_stall", 96'(lat), 96'(23));
        check("stall_used", 96'(stall_left), 96'(0));
        tick();
        check("coords_stall", coords, V1);

        // second frame edge while busy
        check("ovr_before", 96'(overrun), 96'(0));
        set_tab(V2);
        fetch(V1, 1'b0, 5, lat);
        check("lat_ovr", 96'(lat), 96'(13));
        check("ovr_set", 96'(overrun), 96'(1));
        set_tab(V1);
        n = 0;
        repeat (10) begin tick(); n += int'(mem_req); end
        check("ovr_no_refetch", 96'(n), 96'(0));
        check("coords_first", coords, V2);
        check("ovr_sticky", 96'(overrun), 96'(1));

        // reset in the middle of a fetch
        gcnt  = 0;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        k = 0;
        while (k < 50 && !(vga_counter == 3'd3 && !mem_req && !update_done)) begin tick(); k++; end
        check("reach_data3", 96'({mem_req, vga_counter}), 96'({1'b0, 3'd3}));
        rst = 1'b1;
        tick();
        check("mid_rst_req", 96'(mem_req), 96'(0));
        check("mid_rst_coords", coords, 96'(0));
        check("mid_rst_cnt", 96'(vga_counter), 96'(0));
        check("mid_rst_state", 96'(dut.state), 96'(0));
        check("mid_rst_ovr", 96'(overrun), 96'(0));
        rst = 1'b0;
        tick();

        // grant never arrives
        gnt_off = 1'b1;
        frame   = 1'b1;
        lat     = 0;
`ifdef SPR_FETCH_TIMEOUT_EN
        while (lat < 100 && !fetch_err) begin
            tick();
            lat++;
            if (lat == 1) frame = 1'b0;
        end
        check("tmo_lat", 96'(lat), 96'(21));
        tick();
        check("tmo_req", 96'(mem_req), 96'(0));
        check("tmo_err_pulse", 96'(fetch_err), 96'(0));
        check("tmo_coords", coords, 96'(0));
`else
        e = 0;
        repeat (300) begin
            tick();
            lat++;
            if (lat == 1) frame = 1'b0;
            e += int'(fetch_err);
        end
        check("stuck_req", 96'(mem_req), 96'(1));
        check("stuck_addr", 96'(mem_addr), 96'(0));
        check("no_err", 96'(e), 96'(0));
        check("stuck_coords", coords, 96'(0));
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
